router_sync_ctrl: RTL and testbench

Glue controller between the router input FSM, the input register block and the three output FIFOs of the 1x3 router. Latches the destination address at header time and steers write enables and the full flag to and from the addressed FIFO. Drives a valid indication per output port. Runs a per-port read timeout that soft-resets a FIFO whose destination has stopped draining it.

---
 rtl/router_pkg.sv | 10 +
 rtl/router_port_timer.sv | 38 +++
 rtl/router_sync_ctrl.sv | 90 +++++++++
 tb/tb_router_sync_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router control slice.
// Port count, "no port" address code and timeout defaults.
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int DEF_TIMEOUT = 30;
    localparam int DEF_CNT_W = 5;
    localparam logic [1:0] ADDR_NONE = 2'b11;

endpackage

// File: rtl/router_port_timer.sv
// Per-port read timeout: pulses soft_reset for one cycle after
// TIMEOUT consecutive edges with valid data and no read.
module router_port_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic vld,
    input  logic rd_en,
    output logic soft_reset
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Idle counter; restarts on a read or when the port drains,
    // and wraps to zero on the cycle the flush pulse is raised.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            soft_reset <= 1'b0;
        end else if (!vld || rd_en) begin
            cnt <= '0;
            soft_reset <= 1'b0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            soft_reset <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_sync_ctrl.sv
// Router glue: latches the header address, steers FIFO write
// enables and full flag, and runs a flush timer per output port.
module router_sync_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2,
    output logic [1:0] addr_q
);

    // Destination latch; a new header takes effect next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= ADDR_NONE;
        end else if (detect_add) begin
            addr_q <= data_in;
        end
    end

    // One-hot write steering from the registered address.
    always_comb begin
        write_enb = 3'b000;
        if (write_enb_reg && addr_q != ADDR_NONE) begin
            write_enb = 3'b001 << addr_q;
        end
    end

    // Full flag of the addressed FIFO back to the input FSM.
    always_comb begin
        fifo_full = 1'b0;
        case (addr_q)
            2'd0: fifo_full = full_0;
            2'd1: fifo_full = full_1;
            2'd2: fifo_full = full_2;
            default: fifo_full = 1'b0;
        endcase
    end

    assign vld_out_0 = ~empty_0;
    assign vld_out_1 = ~empty_1;
    assign vld_out_2 = ~empty_2;

    router_port_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmr0 (
        .clock(clock),
        .reset(reset),
        .vld(vld_out_0),
        .rd_en(read_enb_0),
        .soft_reset(soft_reset_0)
    );

    router_port_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmr1 (
        .clock(clock),
        .reset(reset),
        .vld(vld_out_1),
        .rd_en(read_enb_1),
        .soft_reset(soft_reset_1)
    );

    router_port_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmr2 (
        .clock(clock),
        .reset(reset),
        .vld(vld_out_2),
        .rd_en(read_enb_2),
        .soft_reset(soft_reset_2)
    );

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Scoreboard bench for router_sync_ctrl: predicted outputs are
// queued when inputs are driven and compared when sampled.
module tb_router_sync_ctrl;

    localparam int T = 30;

    typedef struct packed {
        logic [1:0] addr;
        logic [2:0] wen;
        logic       ffull;
        logic [2:0] vld;
        logic [2:0] sr;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic [2:0] rd;
    logic [2:0] empty;
    logic [2:0] full;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic [1:0] addr_q;

    int checks = 0;
    int errors = 0;

    logic [1:0] m_addr;
    int         m_cnt [3];
    logic [2:0] m_sr;
    exp_t       sb_q [$];

    always #5 clock = ~clock;

    router_sync_ctrl #(.TIMEOUT(T), .CNT_W(5)) dut (
        .clock(clock),
        .reset(reset),
        .detect_add(detect_add),
        .data_in(data_in),
        .write_enb_reg(write_enb_reg),
        .read_enb_0(rd[0]),
        .read_enb_1(rd[1]),
        .read_enb_2(rd[2]),
        .empty_0(empty[0]),
        .empty_1(empty[1]),
        .empty_2(empty[2]),
        .full_0(full[0]),
        .full_1(full[1]),
        .full_2(full[2]),
        .write_enb(write_enb),
        .fifo_full(fifo_full),
        .vld_out_0(vld_out_0),
        .vld_out_1(vld_out_1),
        .vld_out_2(vld_out_2),
        .soft_reset_0(soft_reset_0),
        .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2),
        .addr_q(addr_q)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t predict(input logic [1:0] a,
                                     input logic [2:0] s);
        exp_t e;
        e.addr = a;
        e.sr = s;
        e.vld = ~empty;
        e.wen = 3'b000;
        e.ffull = 1'b0;
        if (a != 2'b11) begin
            if (write_enb_reg) e.wen[a] = 1'b1;
            e.ffull = full[a];
        end
        return e;
    endfunction

    task automatic compare(input string ph);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({ph, "_queue"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check({ph, "_addr"}, int'(addr_q), int'(e.addr));
        check({ph, "_wen"}, int'(write_enb), int'(e.wen));
        check({ph, "_full"}, int'(fifo_full), int'(e.ffull));
        check({ph, "_vld"}, int'({vld_out_2, vld_out_1, vld_out_0}),
              int'(e.vld));
        check({ph, "_srst"},
              int'({soft_reset_2, soft_reset_1, soft_reset_0}),
              int'(e.sr));
    endtask

    // One clock: check combinational view before the edge, then
    // the registered state after it.
    task automatic tick();
        logic [1:0] n_addr;
        int         n_cnt [3];
        logic [2:0] n_sr;
        sb_q.push_back(predict(m_addr, m_sr));
        n_addr = m_addr;
        if (reset) n_addr = 2'b11;
        else if (detect_add) n_addr = data_in;
        for (int i = 0; i < 3; i++) begin
            if (reset || empty[i] || rd[i]) begin
                n_cnt[i] = 0;
                n_sr[i] = 1'b0;
            end else if (m_cnt[i] == T - 1) begin
                n_cnt[i] = 0;
                n_sr[i] = 1'b1;
            end else begin
                n_cnt[i] = m_cnt[i] + 1;
                n_sr[i] = 1'b0;
            end
        end
        sb_q.push_back(predict(n_addr, n_sr));
        #1;
        compare("pre");
        @(posedge clock);
        m_addr = n_addr;
        m_sr = n_sr;
        for (int i = 0; i < 3; i++) m_cnt[i] = n_cnt[i];
        #1;
        compare("post");
    endtask

    initial begin
        int first;
        int second;
        m_addr = 2'b11;
        m_sr = 3'b000;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        reset = 1'b1;
        detect_add = 1'b0;
        data_in = 2'd0;
        write_enb_reg = 1'b0;
        rd = 3'b000;
        empty = 3'b111;
        full = 3'b000;
        @(negedge clock);
        tick();
        tick();
        check("reset_addr", int'(addr_q), 3);
        check("reset_srst",
              int'({soft_reset_2, soft_reset_1, soft_reset_0}), 0);
        reset = 1'b0;

        // address 1 steering and full mux
        detect_add = 1'b1; data_in = 2'd1;
        tick();
        detect_add = 1'b0; write_enb_reg = 1'b1;
        tick();
        check("addr1_wen", int'(write_enb), 2);
        full = 3'b010;
        tick();
        check("full1_sel", int'(fifo_full), 1);
        full = 3'b001;
        tick();
        check("full0_ignored", int'(fifo_full), 0);

        // address 3 selects nothing
        write_enb_reg = 1'b0; detect_add = 1'b1; data_in = 2'd3;
        tick();
        detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b111;
        tick();
        check("none_wen", int'(write_enb), 0);
        check("none_full", int'(fifo_full), 0);

        // same-cycle header and write uses old address
        write_enb_reg = 1'b0; detect_add = 1'b1; data_in = 2'd0;
        full = 3'b000;
        tick();
        data_in = 2'd2; write_enb_reg = 1'b1;
        #1;
        check("old_addr_wen", int'(write_enb), 1);
        tick();
        check("new_addr_wen", int'(write_enb), 4);
        detect_add = 1'b0; write_enb_reg = 1'b0;
        tick();

        // port 2 idle: pulses at edge 30 and 60
        empty = 3'b011;
        first = 0; second = 0;
        for (int i = 1; i <= 65; i++) begin
            tick();
            if (soft_reset_2) begin
                if (first == 0) first = i;
                else if (second == 0) second = i;
            end
        end
        check("p2_first_pulse", first, 30);
        check("p2_second_pulse", second, 60);

        // port 0: read at edge 30 restarts the count
        empty = 3'b110;
        first = 0;
        for (int i = 1; i <= 29; i++) begin
            tick();
            if (soft_reset_0 && first == 0) first = i;
        end
        rd = 3'b001;
        tick();
        if (soft_reset_0 && first == 0) first = 30;
        rd = 3'b000;
        for (int i = 1; i <= 35; i++) begin
            tick();
            if (soft_reset_0 && first == 0) first = 100 + i;
        end
        check("p0_restart_pulse", first, 130);

        // port 1: reset at count 20 discards the count
        empty = 3'b101;
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        check("mid_reset_addr", int'(addr_q), 3);
        check("mid_reset_srst", int'(soft_reset_1), 0);
        reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (soft_reset_1 && first == 0) first = i;
        end
        check("p1_after_reset_pulse", first, 30);

        // random traffic against the model
        for (int i = 0; i < 200; i++) begin
            detect_add = 1'($urandom_range(0, 3) == 0);
            data_in = 2'($urandom_range(0, 3));
            write_enb_reg = 1'($urandom_range(0, 1));
            rd = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7))
                 & 3'($urandom_range(0, 7));
            empty = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            full = 3'($urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
